alu_result_fifo: RTL and testbench

Buffers results from the combinational `alu_4bit` stage so a slower consumer can drain them under a valid/ready handshake. Each push captures the 4-bit result, carry-out and the `op_select` that produced it. Entries leave in first-in, first-out order. The block sits directly downstream of `alu_4bit`. It is the first clocked stage of the ALU datapath.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_result_fifo.sv | 84 ++++++++
 tb/tb_alu_result_fifo.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath constants: op encodings, operand width and result FIFO entry width.
// ALU_RESULT_FIFO_FLAGS_EN adds the zero/borrow flag bits to each FIFO entry.
package alu_pkg;

   localparam logic ALU_OP_ADD = 1'b0;
   localparam logic ALU_OP_SUB = 1'b1;
   localparam int   ALU_DATA_W = 4;

`ifdef ALU_RESULT_FIFO_FLAGS_EN
   localparam int ALU_FIFO_FLAG_W = 2;
`else
   localparam int ALU_FIFO_FLAG_W = 0;
`endif

   // Entry layout from LSB: result, carry, op, then the optional borrow and zero flags.
   localparam int ALU_FIFO_ENTRY_W = ALU_DATA_W + 2 + ALU_FIFO_FLAG_W;

endpackage

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO buffering alu_4bit results for a valid/ready consumer.
// Define ALU_RESULT_FIFO_FLAGS_EN to add the stored out_zero / out_borrow flags.
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = ALU_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_result,
   input  logic                     in_carry,
   input  logic                     in_op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_result,
   output logic                     out_carry,
   output logic                     out_op,
`ifdef ALU_RESULT_FIFO_FLAGS_EN
   output logic                     out_zero,
   output logic                     out_borrow,
`endif
   output logic [$clog2(DEPTH):0]   count
);

   localparam int           AW      = $clog2(DEPTH);
   localparam int           ENTRY_W = DATA_W + 2 + ALU_FIFO_FLAG_W;
   localparam logic [AW:0]  FULL    = (AW+1)'(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] rd_entry;
   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic               push;
   logic               pop;

   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

`ifdef ALU_RESULT_FIFO_FLAGS_EN
   // Flags are derived once at push time so the consumer sees them with no extra logic.
   assign wr_entry = {(in_result == '0), (in_op == ALU_OP_SUB) && !in_carry,
                      in_op, in_carry, in_result};
`else
   assign wr_entry = {in_op, in_carry, in_result};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately unreset; only the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr[AW-1:0]] <= wr_entry;
   end

   assign rd_entry   = mem[rd_ptr[AW-1:0]];
   assign out_result = rd_entry[DATA_W-1:0];
   assign out_carry  = rd_entry[DATA_W];
   assign out_op     = rd_entry[DATA_W+1];

`ifdef ALU_RESULT_FIFO_FLAGS_EN
   assign out_borrow = out_valid & rd_entry[DATA_W+2];
   assign out_zero   = out_valid & rd_entry[DATA_W+3];
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: vector table, directed corner sequences and a
// queue scoreboard that follows every push/pop. Honors ALU_RESULT_FIFO_FLAGS_EN.
module tb_alu_result_fifo;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 4;

   typedef struct {
      logic [3:0] res;
      logic       carry;
      logic       op;
      logic       exp_zero;
      logic       exp_borrow;
   } vec_t;

   typedef struct packed {
      logic [3:0] res;
      logic       carry;
      logic       op;
      logic       zero;
      logic       borrow;
   } sb_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic              in_carry;
   logic              in_op;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic              out_carry;
   logic              out_op;
   logic [2:0]        count;
`ifdef ALU_RESULT_FIFO_FLAGS_EN
   logic              out_zero;
   logic              out_borrow;
`endif

   int   n_chk  = 0;
   int   n_fail = 0;
   sb_t  sb_q[$];
   vec_t tbl[6];

   always #5 clk = ~clk;

   alu_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_carry(in_carry), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_carry(out_carry), .out_op(out_op),
`ifdef ALU_RESULT_FIFO_FLAGS_EN
      .out_zero(out_zero), .out_borrow(out_borrow),
`endif
      .count(count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_vec(input int i);
      in_valid  = 1'b1;
      in_result = tbl[i].res;
      in_carry  = tbl[i].carry;
      in_op     = tbl[i].op;
      step();
      in_valid  = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 2*DEPTH+2 && out_valid; i++) step();
      out_ready = 1'b0;
      chk("drain_empty", 32'(count), 0);
   endtask

   // Monitor: handshakes are sampled mid-cycle, where inputs and state are stable until the next edge.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
      end else begin
         chk("mon_count",     32'(count),     32'(sb_q.size()));
         chk("mon_out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
         chk("mon_in_ready",  32'(in_ready),  32'(sb_q.size() != DEPTH));
`ifdef ALU_RESULT_FIFO_FLAGS_EN
         if (!out_valid) chk("mon_idle_flags", {30'd0, out_zero, out_borrow}, 0);
`endif
         if (out_valid && out_ready && sb_q.size() != 0) begin
            chk("sb_result", 32'(out_result), 32'(sb_q[0].res));
            chk("sb_carry",  32'(out_carry),  32'(sb_q[0].carry));
            chk("sb_op",     32'(out_op),     32'(sb_q[0].op));
`ifdef ALU_RESULT_FIFO_FLAGS_EN
            chk("sb_zero",   32'(out_zero),   32'(sb_q[0].zero));
            chk("sb_borrow", 32'(out_borrow), 32'(sb_q[0].borrow));
`endif
            void'(sb_q.pop_front());
         end
         if (in_valid && sb_q.size() < DEPTH)
            sb_q.push_back('{res: in_result, carry: in_carry, op: in_op,
                             zero: (in_result == 4'd0), borrow: (in_op && !in_carry)});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{4'd8,  1'b0, 1'b0, 1'b0, 1'b0};  // 3+5
      tbl[1] = '{4'd1,  1'b1, 1'b0, 1'b0, 1'b0};  // 9+8
      tbl[2] = '{4'd4,  1'b1, 1'b1, 1'b0, 1'b0};  // 7-3
      tbl[3] = '{4'd12, 1'b0, 1'b1, 1'b0, 1'b1};  // 3-7
      tbl[4] = '{4'd0,  1'b1, 1'b0, 1'b1, 1'b0};  // 8+8
      tbl[5] = '{4'd6,  1'b0, 1'b0, 1'b0, 1'b0};  // 1+5

      rst = 1'b1; in_valid = 1'b0; in_result = '0; in_carry = 1'b0; in_op = 1'b0;
      out_ready = 1'b0;
      step(); step();
      chk("rst_count",     32'(count),     0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready",  32'(in_ready),  1);
`ifdef ALU_RESULT_FIFO_FLAGS_EN
      chk("rst_flags", {30'd0, out_zero, out_borrow}, 0);
`endif
      rst = 1'b0;
      step();

      // single push, one-cycle latency
      push_vec(0);
      chk("t1_out_valid", 32'(out_valid),  1);
      chk("t1_result",    32'(out_result), 8);
      chk("t1_carry",     32'(out_carry),  0);
      chk("t1_count",     32'(count),      1);
`ifdef ALU_RESULT_FIFO_FLAGS_EN
      chk("t1_zero",   32'(out_zero),   32'(tbl[0].exp_zero));
      chk("t1_borrow", 32'(out_borrow), 32'(tbl[0].exp_borrow));
`endif
      drain();

      // fill, blocked fifth push, ordered drain
      for (int i = 0; i < 4; i++) push_vec(i);
      chk("t2_count_full", 32'(count),    4);
      chk("t2_in_ready",   32'(in_ready), 0);
      push_vec(5);
      chk("t2_count_hold", 32'(count),    4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_head_result", 32'(out_result), 32'(tbl[i].res));
         chk("t2_head_carry",  32'(out_carry),  32'(tbl[i].carry));
         chk("t2_head_op",     32'(out_op),     32'(tbl[i].op));
`ifdef ALU_RESULT_FIFO_FLAGS_EN
         chk("t2_head_borrow", 32'(out_borrow), 32'(tbl[i].exp_borrow));
`endif
         step();
      end
      out_ready = 1'b0;
      chk("t2_count_empty", 32'(count),     0);
      chk("t2_out_valid",   32'(out_valid), 0);

      // pop while full frees a slot only after the edge
      for (int i = 0; i < 4; i++) push_vec(i);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t3_in_ready", 32'(in_ready), 1);
      chk("t3_count",    32'(count),    3);
      push_vec(5);
      chk("t3_count_refill", 32'(count),    4);
      chk("t3_in_ready_lo",  32'(in_ready), 0);
      drain();

      // streaming push+pop at count 2 across pointer wrap
      push_vec(0);
      push_vec(1);
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_valid  = 1'b1;
         in_result = 4'(k);
         in_carry  = 1'b0;
         in_op     = 1'b0;
         step();
         chk("t4_count", 32'(count), 2);
      end
      in_valid = 1'b0;
      drain();

      // reset at count 3 with a coincident push
      for (int i = 0; i < 3; i++) push_vec(i);
      chk("t5_count_pre", 32'(count), 3);
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_result = tbl[5].res;
      in_carry  = tbl[5].carry;
      in_op     = tbl[5].op;
      step();
      chk("t5_count",     32'(count),     0);
      chk("t5_out_valid", 32'(out_valid), 0);
      chk("t5_in_ready",  32'(in_ready),  1);
      rst      = 1'b0;
      in_valid = 1'b0;
      step();
      chk("t5_not_stored", 32'(count), 0);

      // zero result
      push_vec(4);
      chk("t6_out_valid", 32'(out_valid),  1);
      chk("t6_result",    32'(out_result), 0);
      chk("t6_carry",     32'(out_carry),  1);
`ifdef ALU_RESULT_FIFO_FLAGS_EN
      chk("t6_zero",   32'(out_zero),   32'(tbl[4].exp_zero));
      chk("t6_borrow", 32'(out_borrow), 32'(tbl[4].exp_borrow));
`endif
      drain();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
